// File: rtl/puf_arb_pkg.sv
// Shared types and encodings for the PUF race arbiter.
package puf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    localparam logic RESP_A_FIRST = 1'b0;
    localparam logic RESP_B_FIRST = 1'b1;

endpackage

// File: rtl/puf_edge_sync.sv
// Per-bit synchroniser chain followed by a history flop; emits a one-cycle
// rise pulse for every 0->1 transition seen after synchronisation.
module puf_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync;
    logic [W-1:0] prev;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sync = din;
        end else begin : g_sync
            logic [W-1:0] stage [SYNC_STAGES];

            // Shift the raw input through the synchroniser chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign sync = stage[SYNC_STAGES-1];
        end
    endgenerate

    // History flop runs in every state so a level already high at arm time is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/puf_race_arbiter.sv
// Multi-channel race arbiter: records per channel which race input rose first
// after arming, bounded by a timeout, and presents the word over valid/ready.
module puf_race_arbiter
    import puf_arb_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] race_a,
    input  logic [NUM_CH-1:0] race_b,
    output logic              busy,
    output logic [NUM_CH-1:0] resp,
    output logic [NUM_CH-1:0] tie,
    output logic [NUM_CH-1:0] done_mask,
    output logic              timeout,
    output logic              resp_valid,
    input  logic              resp_ready
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e        state;
    logic [CW-1:0]     cnt;
    logic [NUM_CH-1:0] rise_a;
    logic [NUM_CH-1:0] rise_b;
    logic [NUM_CH-1:0] resp_nxt;
    logic [NUM_CH-1:0] tie_nxt;
    logic [NUM_CH-1:0] done_nxt;

    puf_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (NUM_CH)
    ) u_sync_a (
        .clk  (clk),
        .rst  (rst),
        .din  (race_a),
        .rise (rise_a)
    );

    puf_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (NUM_CH)
    ) u_sync_b (
        .clk  (clk),
        .rst  (rst),
        .din  (race_b),
        .rise (rise_b)
    );

    // Per-channel decision for this cycle; decided channels are frozen
    always_comb begin
        resp_nxt = resp;
        tie_nxt  = tie;
        done_nxt = done_mask;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!done_mask[i] && (rise_a[i] || rise_b[i])) begin
                done_nxt[i] = 1'b1;
                tie_nxt[i]  = rise_a[i] & rise_b[i];
                resp_nxt[i] = (rise_b[i] && !rise_a[i]) ? RESP_B_FIRST : RESP_A_FIRST;
            end
        end
    end

    // Control FSM with registered status outputs and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            resp       <= '0;
            tie        <= '0;
            done_mask  <= '0;
            timeout    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        resp      <= '0;
                        tie       <= '0;
                        done_mask <= '0;
                        timeout   <= 1'b0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    cnt       <= cnt + CW'(1);
                    resp      <= resp_nxt;
                    tie       <= tie_nxt;
                    done_mask <= done_nxt;
                    if (&done_nxt) begin
                        resp_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        timeout    <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_race_arbiter.sv
// Directed self-checking bench for puf_race_arbiter (4 channels, 2 sync stages, timeout 16).
module tb_puf_race_arbiter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] race_a;
    logic [3:0] race_b;
    logic       busy;
    logic [3:0] resp;
    logic [3:0] tie;
    logic [3:0] done_mask;
    logic       timeout;
    logic       resp_valid;
    logic       resp_ready;

    int vectors;
    int miscompares;

    puf_race_arbiter #(
        .NUM_CH      (4),
        .SYNC_STAGES (2),
        .TIMEOUT     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .race_a     (race_a),
        .race_b     (race_b),
        .busy       (busy),
        .resp       (resp),
        .tie        (tie),
        .done_mask  (done_mask),
        .timeout    (timeout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        race_a      = 4'h0;
        race_b      = 4'h0;
        resp_ready  = 1'b0;

        // Reset state
        tick(2);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_resp", resp, 4'h0);
        check("rst_done", done_mask, 4'h0);
        check("rst_tie_to", {tie, timeout}, 5'h00);
        rst = 1'b0;
        tick(2);

        // Basic decide: B on ch0, then A on ch1..3 one cycle apart
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_busy", busy, 1'b1);
        race_b[0] = 1'b1;
        tick();
        race_a[1] = 1'b1;
        tick();
        race_a[2] = 1'b1;
        tick();
        check("basic_done_ch0", done_mask, 4'b0001);
        race_a[3] = 1'b1;
        tick(2);
        check("basic_done_partial", done_mask, 4'b0111);
        check("basic_valid_early", resp_valid, 1'b0);
        tick();
        check("basic_valid", resp_valid, 1'b1);
        check("basic_resp", resp, 4'b0001);
        check("basic_done", done_mask, 4'hF);
        check("basic_tie_to", {tie, timeout}, 5'h00);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("basic_accept", {resp_valid, busy}, 2'b00);
        check("basic_held_idle", {resp, done_mask}, 8'h1F);
        race_a = 4'h0;
        race_b = 4'h0;
        tick(3);

        // Tie on ch2, others decided in the same cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        race_a = 4'b1101;
        race_b = 4'b0110;
        tick(3);
        check("tie_valid", resp_valid, 1'b1);
        check("tie_tie", tie, 4'b0100);
        check("tie_resp", resp, 4'b0010);
        check("tie_done", done_mask, 4'hF);
        check("tie_to", timeout, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        race_a = 4'h0;
        race_b = 4'h0;
        tick(3);

        // Timeout: only ch0 (B) and ch3 (A) ever rise
        start = 1'b1;
        tick();
        start = 1'b0;
        race_b[0] = 1'b1;
        race_a[3] = 1'b1;
        tick(15);
        check("to_not_yet", {resp_valid, busy, timeout}, 3'b010);
        tick();
        check("to_valid", resp_valid, 1'b1);
        check("to_flag", timeout, 1'b1);
        check("to_done", done_mask, 4'b1001);
        check("to_resp", resp, 4'b0001);
        check("to_tie", tie, 4'h0);

        // Backpressure with a start pulse during HOLD
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tick();
            check("bp_hold", {resp_valid, busy, timeout, tie, resp, done_mask}, 15'h7019);
        end
        start = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_release", {resp_valid, busy}, 2'b00);
        check("bp_idle_held", {timeout, resp, done_mask}, 9'h119);
        race_a = 4'h0;
        race_b = 4'h0;
        tick(3);

        // Pre-armed A level, then B rises; a repeat B pulse changes nothing
        race_a = 4'hF;
        tick(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        race_b = 4'hF;
        tick(3);
        check("pre_valid", resp_valid, 1'b1);
        check("pre_resp", resp, 4'hF);
        check("pre_done_tie", {done_mask, tie}, 8'hF0);
        race_b = 4'h0;
        tick(2);
        race_b = 4'hF;
        tick(4);
        check("repeat_stable", {resp_valid, resp, tie, done_mask}, 13'h1F0F);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        race_a = 4'h0;
        race_b = 4'h0;
        tick(3);

        // Reset mid-ARMED with two channels decided
        start = 1'b1;
        tick();
        start = 1'b0;
        race_a[0] = 1'b1;
        race_b[1] = 1'b1;
        tick(3);
        check("mid_done", done_mask, 4'b0011);
        check("mid_busy", {busy, resp_valid}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {busy, resp_valid, timeout, resp, tie, done_mask}, 15'h0000);
        tick();
        rst = 1'b0;
        race_a[2] = 1'b1;
        race_b[3] = 1'b1;
        tick(5);
        check("post_rst_idle", {busy, resp_valid, resp, tie, done_mask}, 14'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
